// File: rtl/full_adder_core.sv
// full_adder_core
//   Ripple-carry full adder with an optional registered copy of the result.
//   This is the basic arithmetic cell of the 16-bit MIPS datapath. The wider
//   adders and the ALU instantiate it.
//   The combinational outputs (sum, carry) depend only on A, B and Cin.
//   They stay correct even when clk/rst are left unconnected.
//
// Parameters
//   WIDTH   : operand width in bits (1 = classic single-bit full adder)
//
// Ports
//   clk     : rising-edge clock, used by the registered outputs only
//   rst     : asynchronous active-high reset, clears sum_q/carry_q only
//   A, B    : WIDTH-bit unsigned addends
//   Cin     : carry into bit 0
//   sum     : combinational sum bits
//   carry   : combinational carry out of the MSB
//   sum_q   : sum registered on the rising clk edge
//   carry_q : carry registered on the rising clk edge
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
);

  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  // Each bit cell is two half adders plus an OR of their carries.
  // The carry ripples through per-cell signals rather than through one
  // shared vector. As a result, no net depends on other bits of itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic cell_cin;
    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;
    logic cell_cout;

    if (i == 0) begin : g_first
      assign cell_cin = Cin;
    end else begin : g_chain
      assign cell_cin = g_cell[i-1].cell_cout;
    end

    assign ha1_sum   = A[i] ^ B[i];
    assign ha1_carry = A[i] & B[i];
    assign sum[i]    = ha1_sum ^ cell_cin;
    assign ha2_carry = ha1_sum & cell_cin;
    assign cell_cout = ha1_carry | ha2_carry;
  end

  assign carry = g_cell[WIDTH-1].cell_cout;

  always_comb begin
    sum_d   = sum;
    carry_d = carry;
  end

  // Reset has priority over a coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core
//   Directed and randomized checks of full_adder_core.
//   The bench uses a 1-bit instance and a 16-bit instance.
//   Expected values come from plain integer addition of A + B + Cin.
module tb_full_adder_core;

  logic        clk;
  logic        rst;

  logic        a1;
  logic        b1;
  logic        cin1;
  logic        sum1;
  logic        carry1;
  logic        sum_q1;
  logic        carry_q1;

  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic [15:0] sum16;
  logic        carry16;
  logic [15:0] sum_q16;
  logic        carry_q16;

  int n_checks;
  int n_fail;

  full_adder_core #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .A       (a1),
    .B       (b1),
    .Cin     (cin1),
    .sum     (sum1),
    .carry   (carry1),
    .sum_q   (sum_q1),
    .carry_q (carry_q1)
  );

  full_adder_core #(.WIDTH(16)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .A       (a16),
    .B       (b16),
    .Cin     (cin16),
    .sum     (sum16),
    .carry   (carry16),
    .sum_q   (sum_q16),
    .carry_q (carry_q16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the unsigned WIDTH+1-bit sum A + B + Cin.
  function automatic logic [31:0] ref_add(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned total;
    total = a + b + c;
    return total;
  endfunction

  initial begin
    logic [2:0]  tt_vec [8];
    logic [31:0] exp_now;
    logic [31:0] exp_reg;

    n_checks = 0;
    n_fail   = 0;

    tt_vec[0] = 3'b000; tt_vec[1] = 3'b100; tt_vec[2] = 3'b010; tt_vec[3] = 3'b110;
    tt_vec[4] = 3'b001; tt_vec[5] = 3'b101; tt_vec[6] = 3'b011; tt_vec[7] = 3'b111;

    rst   = 1'b1;
    a1    = 1'b0;
    b1    = 1'b0;
    cin1  = 1'b0;
    a16   = '0;
    b16   = '0;
    cin16 = 1'b0;

    // The 1-bit truth table, taken while reset is held and the clock runs.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = tt_vec[i];
      #40;
      exp_now = ref_add(32'(a1), 32'(b1), 32'(cin1));
      check($sformatf("truth_table_%0d", i), {30'd0, carry1, sum1}, exp_now);
    end

    check("reset_sum_q1",    {31'd0, sum_q1},    32'd0);
    check("reset_carry_q1",  {31'd0, carry_q1},  32'd0);
    check("reset_sum_q16",   {16'd0, sum_q16},   32'd0);
    check("reset_carry_q16", {31'd0, carry_q16}, 32'd0);

    // Boundaries of the 16-bit ripple chain.
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
    #10;
    check("ripple_full_chain", {15'd0, carry16, sum16}, 32'h10000);
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    #10;
    check("all_ones_max", {15'd0, carry16, sum16}, 32'h1FFFF);
    a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    #10;
    check("all_zero", {15'd0, carry16, sum16}, 32'h0);

    // Registered path: release reset, then capture 1+1+0.
    @(negedge clk);
    rst  = 1'b0;
    a1   = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk); #1;
    check("reg_sum_q_after_1p1",   {31'd0, sum_q1},   32'd0);
    check("reg_carry_q_after_1p1", {31'd0, carry_q1}, 32'd1);

    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    check("reg_sum_q_after_1p0",   {31'd0, sum_q1},   32'd1);
    check("reg_carry_q_after_1p0", {31'd0, carry_q1}, 32'd0);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum_q",    {31'd0, sum_q1}, 32'd0);
    check("async_rst_comb_sum", {31'd0, sum1},   32'd1);
    @(negedge clk);
    check("rst_hold_sum_q16", {16'd0, sum_q16}, 32'd0);
    rst = 1'b0;

    // Randomized 16-bit vectors. Each comb result is checked immediately.
    // Each registered result is checked after the following rising edge.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom);
      exp_now = ref_add(32'(a16), 32'(b16), 32'(cin16));
      #1;
      check("rand_comb", {15'd0, carry16, sum16}, exp_now);
      exp_reg = exp_now;
      @(posedge clk); #1;
      check("rand_reg", {15'd0, carry_q16, sum_q16}, exp_reg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_core.md
# full_adder_core

Combinational full adder, parameterizable as a ripple-carry chain, with an optional registered copy of the result. It is the basic arithmetic cell of the 16-bit MIPS datapath and is instantiated by wider adders and the ALU. The combinational outputs never depend on the clock or reset. They must produce correct results even when `clk` and `rst` are left unconnected.

## Interface
Parameters:
- `WIDTH`, default 1: operand width in bits. With the default of 1, the block is a classic 1-bit full adder.

Ports:
- `clk`, input, 1: clock for the registered outputs only. One clock; rising-edge active.
- `rst`, input, 1: reset, asynchronous and active-high. Clears the registered outputs only.
- `A`, input, WIDTH: addend A.
- `B`, input, WIDTH: addend B.
- `Cin`, input, 1: carry into bit 0.
- `sum`, output, WIDTH: combinational sum bits.
- `carry`, output, 1: combinational carry out of the MSB.
- `sum_q`, output, WIDTH: registered `sum`.
- `carry_q`, output, 1: registered `carry`.

## Operation
- Bit cell i:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]))
  - c[0] = Cin
- Implement each cell as two half adders plus an OR of the two half-adder carries. Chain the cells by ripple from bit 0 to bit WIDTH-1.
- Outputs:
  - `sum` = s[WIDTH-1:0]
  - `carry` = c[WIDTH]
  - Equivalently, {carry, sum} = A + B + Cin, computed as a WIDTH+1-bit unsigned sum with no truncation.
- Arithmetic is unsigned. No overflow flag and no signed interpretation.
- All-ones boundary: A = B = 2^WIDTH−1 with Cin = 1 gives sum = all ones and carry = 1. This is the maximum result and must not wrap incorrectly.
- Registered path:
  - On each rising `clk` edge, `sum_q` <= `sum` and `carry_q` <= `carry`.
  - While `rst` = 1, `sum_q` = 0 and `carry_q` = 0, regardless of `clk`.
- X/Z on any input bit may propagate only to the `sum`/`carry` bits that logically depend on it.

## Timing
- `sum` and `carry` are purely combinational, with zero cycles of latency. They settle within one propagation delay after any change of `A`, `B` or `Cin`. For WIDTH > 1, the worst-case delay grows linearly with WIDTH (ripple).
- `sum_q` and `carry_q` have one-cycle latency. They reflect the inputs present at the preceding rising edge.
- Reset values: `sum_q` = 0 and `carry_q` = 0. `sum` and `carry` have no reset value; they always track the inputs.
- Reset assertion clears `sum_q`/`carry_q` immediately (asynchronous), even mid-operation.
- Reset deassertion: the first capture happens at the first rising edge after `rst` falls.
- If `rst` and a clock edge occur together, reset wins.
- No handshake and no state machine.

## Test plan
- Exhaustive 1-bit truth table, WIDTH = 1, `clk`/`rst` undriven. Step (A,B,Cin) through 000, 100, 010, 110, 001, 101, 011, 111, holding each for 40 ns. Required {carry,sum}: 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH = 16, A = 0xFFFF, B = 0x0000, Cin = 1 -> sum = 0x0000, carry = 1. This checks the full ripple chain.
- WIDTH = 16, A = 0xFFFF, B = 0xFFFF, Cin = 1 -> sum = 0xFFFF, carry = 1.
- Registered path, WIDTH = 1:
  - Hold `rst` = 1 -> `sum_q` = 0 and `carry_q` = 0.
  - Release `rst`, apply A = 1, B = 1, Cin = 0 -> after the next rising edge, `sum_q` = 0 and `carry_q` = 1.
- Asynchronous reset mid-run: with `sum_q` = 1, assert `rst` between clock edges -> `sum_q` drops to 0 immediately. The combinational `sum` is unaffected.
- Randomized check, WIDTH = 16, 1000 vectors: {carry,sum} equals A + B + Cin for every vector.
